mux8_1: RTL and testbench
=========================

MUX8_1 -- requirements
Module: mux8_1

Interface
- REQ-001: Parameter WIDTH, default 64, SHALL set the bit width of each data lane and of the output.
- REQ-002: Port clk, input, 1, SHALL be the single rising-edge clock.
- REQ-003: Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
- REQ-004: Port en, input, 1, SHALL be the output-register load enable.
- REQ-005: Port sel, input, 3, SHALL be the lane select, 0..7.
- REQ-006: Port in, input, 8*WIDTH, SHALL hold the packed data lanes; lane k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
- REQ-007: Port out, output, WIDTH, SHALL carry the selected lane.

Function
- REQ-008: The selected value SHALL equal lane sel of in, bit-for-bit, for every sel value 0..7.
- REQ-009: Selection SHALL be bitwise-independent: bit i of the selected value SHALL depend only on bit i of each lane and on sel.
- REQ-010: Selection SHALL be a 2:1-of-4:1 tree.
  - sel[2]=0 picks from lanes 0..3; sel[2]=1 picks from lanes 4..7.
  - sel[1:0] picks within the chosen half.
- REQ-011: No lane SHALL be reserved or forced to zero internally; callers needing constant lanes tie them externally.
- REQ-012: With the register compiled in (REQ-017), out SHALL update on the rising clk edge to the value selected at that edge when en=1.
- REQ-013: In that registered mode, latency SHALL be exactly 1 cycle from a sel/in change to out.
- REQ-014: In that registered mode, out SHALL hold its value on a rising edge where en=0, regardless of sel or in changes.
- REQ-015: When sel and in change in the same cycle as en=1, out SHALL take the new lane's new data at the next edge.

Reset
- REQ-016: rst_n=0 SHALL drive out to all-zero immediately, independent of clk, en, sel and in.
  - Assertion during an update cycle SHALL override that update.
  - After deassertion, out SHALL remain zero until the first rising edge with en=1.

Configuration
- REQ-017: Macro MUX8_1_OUTREG_EN SHALL control the output register.
  - Defined: out is registered per REQ-012..REQ-016.
  - Undefined: out is the purely combinational selection with zero latency; clk, rst_n and en are ignored and no storage is inferred.

Verification
- REQ-018: Registered mode, reset asserted mid-run -> out=0 immediately; out stays 0 after release until the first edge with en=1.
- REQ-019: WIDTH=64 with lanes 0=10, 1=0, 2=100, 3=64, 4=-2418 (two's complement), 5=10000, 6=1, 7=0.
  - en=1, sel stepped 0, 2, 3, 4, 5, 6, each held 5 cycles.
  - Required out: 10, 100, 64, 0xFFFFFFFFFFFFF68E, 10000, 1, each one cycle after the sel change.
- REQ-020: sel=1 and sel=7 with lanes 1 and 7 set to 0xA5A5A5A5A5A5A5A5 and 0x5A5A5A5A5A5A5A5A -> out equals those values (no internal zero lanes).
- REQ-021: en=0 and sel changed from 0 to 5 -> out holds 10 for 3 cycles; en=1 -> out=10000 on the next edge.
- REQ-022: Walking-one on lane 3 (bit i set, i=0..63), sel=3 -> out has only bit i set; all other sels -> bit i clear.
- REQ-023: Macro undefined, sel changed with clk stopped -> out follows sel within the same timestep.

Source files
------------

// File: rtl/mux8_1.sv
// 8:1 lane multiplexer built as a 2:1-of-4:1 tree, optionally followed by an
// enabled output register (define MUX8_1_OUTREG_EN to compile the register in).
module mux8_1 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [2:0]         sel,
  input  logic [8*WIDTH-1:0] in,
  output logic [WIDTH-1:0]   out
);

  logic [WIDTH-1:0] lane [8];
  logic [WIDTH-1:0] lo_half;
  logic [WIDTH-1:0] hi_half;
  logic [WIDTH-1:0] out_d;

  for (genvar k = 0; k < 8; k++) begin : g_unpack
    assign lane[k] = in[k*WIDTH +: WIDTH];
  end

  // Each half picks with sel[1:0]; sel[2] then chooses between the halves.
  assign lo_half = lane[{1'b0, sel[1:0]}];
  assign hi_half = lane[{1'b1, sel[1:0]}];
  assign out_d   = sel[2] ? hi_half : lo_half;

`ifdef MUX8_1_OUTREG_EN
  logic [WIDTH-1:0] out_q;

  // NOTE: non-blocking assignment keeps the register update order-independent;
  // the async clear wins over any load happening in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (en) begin
      out_q <= out_d;
    end
  end

  assign out = out_q;
`else
  logic unused_ctrl;

  assign unused_ctrl = ^{clk, rst_n, en};
  assign out         = out_d;
`endif

endmodule

// File: tb/tb_mux8_1.sv
// Directed self-checking bench for mux8_1 (WIDTH=64); covers both the
// registered build (MUX8_1_OUTREG_EN) and the default combinational build.
module tb_mux8_1;

  localparam int unsigned W = 64;

  logic           clk;
  logic           clk_run;
  logic           rst_n;
  logic           en;
  logic [2:0]     sel;
  logic [8*W-1:0] in;
  logic [W-1:0]   out;

  logic [W-1:0]   lanes [8];
  int             n_cmp;
  int             n_err;

  mux8_1 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .sel   (sel),
    .in    (in),
    .out   (out)
  );

  initial begin
    clk     = 1'b0;
    clk_run = 1'b1;
  end

  always #5 if (clk_run) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_lanes();
    for (int k = 0; k < 8; k++) in[k*W +: W] = lanes[k];
  endtask

  // Registered build: one clock edge, then sample 1 ns later.
  // Combinational build: sample 1 ns after driving.
  task automatic settle();
`ifdef MUX8_1_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic load_base_lanes();
    lanes[0] = 64'd10;
    lanes[1] = 64'd0;
    lanes[2] = 64'd100;
    lanes[3] = 64'd64;
    lanes[4] = 64'hFFFF_FFFF_FFFF_F68E;
    lanes[5] = 64'd10000;
    lanes[6] = 64'd1;
    lanes[7] = 64'd0;
    drive_lanes();
  endtask

  logic [2:0]   step_sel [6];
  logic [W-1:0] step_exp [6];
  logic [W-1:0] prev;
  logic [W-1:0] exp_v;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 3'd0;
    in    = '0;
    load_base_lanes();

    // Reset behaviour
    #1;
`ifdef MUX8_1_OUTREG_EN
    check("rst_out", out, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    settle();
    check("post_rst_en0", out, '0);
    prev = '0;
`else
    check("comb_rst_ignored", out, 64'd10);
    rst_n = 1'b1;
    prev  = 64'd10;
`endif

    // Lane stepping, each sel held 5 cycles
    en = 1'b1;
    step_sel = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    step_exp = '{64'd10, 64'd100, 64'd64, 64'hFFFF_FFFF_FFFF_F68E, 64'd10000, 64'd1};
    for (int s = 0; s < 6; s++) begin
      sel = step_sel[s];
`ifdef MUX8_1_OUTREG_EN
      #1;
      check($sformatf("latency_sel%0d", step_sel[s]), out, prev);
`endif
      settle();
      check($sformatf("step_sel%0d", step_sel[s]), out, step_exp[s]);
      for (int c = 0; c < 4; c++) begin
        settle();
        check($sformatf("hold_sel%0d_c%0d", step_sel[s], c), out, step_exp[s]);
      end
      prev = step_exp[s];
    end

    // Enable low holds the register while sel moves
    sel = 3'd0;
    settle();
    check("en_setup", out, 64'd10);
    en  = 1'b0;
    sel = 3'd5;
    for (int c = 0; c < 3; c++) begin
      settle();
`ifdef MUX8_1_OUTREG_EN
      check($sformatf("en0_hold_c%0d", c), out, 64'd10);
`else
      check($sformatf("comb_en_ignored_c%0d", c), out, 64'd10000);
`endif
    end
    en = 1'b1;
    settle();
    check("en1_reload", out, 64'd10000);

    // No internal zero lanes
    lanes[1] = 64'hA5A5_A5A5_A5A5_A5A5;
    lanes[7] = 64'h5A5A_5A5A_5A5A_5A5A;
    drive_lanes();
    sel = 3'd1;
    settle();
    check("lane1_pattern", out, 64'hA5A5_A5A5_A5A5_A5A5);
    sel = 3'd7;
    settle();
    check("lane7_pattern", out, 64'h5A5A_5A5A_5A5A_5A5A);

    // sel and data change together
    lanes[2] = 64'h0123_4567_89AB_CDEF;
    drive_lanes();
    sel = 3'd2;
    settle();
    check("sel_and_data", out, 64'h0123_4567_89AB_CDEF);

    // Random lanes against a slice model
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) lanes[k] = {$urandom(), $urandom()};
      drive_lanes();
      for (int s = 0; s < 8; s++) begin
        sel = 3'(s);
        settle();
        check($sformatf("rand_r%0d_sel%0d", r, s), out, lanes[s]);
      end
    end

    // Walking one on lane 3
    for (int k = 0; k < 8; k++) lanes[k] = '0;
    for (int i = 0; i < 64; i++) begin
      lanes[3] = 64'd1 << i;
      drive_lanes();
      for (int s = 0; s < 8; s++) begin
        sel = 3'(s);
        settle();
        exp_v = (s == 3) ? (64'd1 << i) : 64'd0;
        check($sformatf("walk_b%0d_sel%0d", i, s), out, exp_v);
      end
    end

    // Reset asserted mid-run
    lanes[7] = 64'h5A5A_5A5A_5A5A_5A5A;
    drive_lanes();
    sel = 3'd7;
    settle();
    check("pre_rst_value", out, 64'h5A5A_5A5A_5A5A_5A5A);
`ifdef MUX8_1_OUTREG_EN
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", out, '0);
    settle();
    check("rst_overrides_load", out, '0);
    en    = 1'b0;
    rst_n = 1'b1;
    settle();
    settle();
    check("rst_release_hold", out, '0);
    en = 1'b1;
    settle();
    check("rst_first_load", out, 64'h5A5A_5A5A_5A5A_5A5A);
`else
    rst_n = 1'b0;
    #1;
    check("comb_rst_no_effect", out, 64'h5A5A_5A5A_5A5A_5A5A);
    rst_n = 1'b1;

    // Clock stopped: output still tracks sel
    clk_run = 1'b0;
    lanes[4] = 64'hDEAD_BEEF_0000_0004;
    drive_lanes();
    sel = 3'd4;
    #1;
    check("clk_stopped_follow", out, 64'hDEAD_BEEF_0000_0004);
    sel = 3'd3;
    #1;
    check("clk_stopped_follow2", out, 64'd1 << 63);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
